time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//  Consumes the 1 Hz single-cycle tick from the seconds-tick generator and keeps
//  24-hour time of day as packed BCD HH:MM:SS for the 7-segment display driver.
//  Small FSM lets the user set hours/minutes with two debounced buttons.
//  Sits between tick generator (upstream) and display mux/decoder (downstream).
// PARAMETERS
//  RST_HH  8'h12  BCD hours loaded on reset (must be 00..23)
//  RST_MM  8'h00  BCD minutes loaded on reset (must be 00..59)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  tick_1s    in   1  one-clk pulse per second, synchronous to clk
//  mode_btn   in   1  one-clk pulse, debounced upstream; cycles RUN->SET_HH->SET_MM->RUN
//  inc_btn    in   1  one-clk pulse, debounced upstream; increments selected field
//  hh_bcd     out  8  hours, BCD 00..23 ([7:4] tens, [3:0] units)
//  mm_bcd     out  8  minutes, BCD 00..59
//  ss_bcd     out  8  seconds, BCD 00..59
//  set_field  out  2  00 RUN, 01 editing hours, 10 editing minutes (display blink)
//  day_wrap   out  1  one-clk pulse when 23:59:59 rolls to 00:00:00
//  alarm_ring out  1  (ALARM_EN only) see CONFIGURATION
// BEHAVIOUR
//  - Clock is clk; reset is asynchronous, active-high. Reset: hh=RST_HH, mm=RST_MM,
//    ss=00, state=RUN, set_field=00, day_wrap=0, alarm_ring=0.
//  - All outputs registered; event in cycle n visible in cycle n+1 (latency 1).
//  - RUN: tick_1s -> ss+1; ss 59->00 carries mm+1; mm 59->00 carries hh+1;
//    hh 23->00 with day_wrap=1 for exactly that cycle. Units digit 9->0 carries tens.
//  - inc_btn ignored in RUN. tick_1s ignored in SET_HH/SET_MM (time frozen).
//  - SET_HH: inc_btn -> hh+1, 23->00, no carry, no day_wrap.
//  - SET_MM: inc_btn -> mm+1, 59->00, no carry into hh.
//  - Leaving SET_MM (mode_btn) -> RUN and ss forced to 00 in the same update.
//  - Simultaneous tick_1s and mode_btn in RUN: tick applied, state -> SET_HH.
//  - Simultaneous inc_btn and mode_btn in SET: mode wins, increment dropped.
//  - Out-of-range BCD never produced; illegal FSM encoding recovers to RUN.
//  - Reset mid-edit aborts edit: values revert to reset values immediately.
// CONFIGURATION
//  Macro TOD_ALARM_EN:
//  - defined: adds inputs alarm_hh[7:0], alarm_mm[7:0] (BCD) and alarm_arm (level);
//    alarm_ring rises in the update where time becomes alarm_hh:alarm_mm:00 in RUN
//    with alarm_arm=1; stays high until mode_btn/inc_btn pulse, alarm_arm=0, or
//    60 s elapse; button pulse that silences the alarm has no other effect.
//  - undefined: alarm ports absent, alarm_ring not present; no alarm logic.
// STRUCTURE
//  - Package tod_pkg: FSM state typedef {RUN, SET_HH, SET_MM} 2-bit,
//    constants BCD_59=8'h59, BCD_23=8'h23, SET_FIELD_* encodings.
//  - Sub-module bcd_mod_counter #(MAX_BCD): 8-bit BCD counter, inputs inc,
//    outputs value and carry (carry=inc && value==MAX_BCD); instanced x3.
//  - Top holds FSM, carry chaining/gating, day_wrap and alarm register.
// TESTING
//  - Reset with defaults -> 12:00:00, set_field=00, day_wrap=0.
//  - Preload 23:59:58 via SET, 2 ticks -> 23:59:59 then 00:00:00, day_wrap 1 clk.
//  - RUN at 10:59:59, 1 tick -> 11:00:00; ss units 9->0 carries tens correctly.
//  - mode_btn, 13 inc_btn -> hh 12->01 wraps via 23->00; mode, inc -> mm+1;
//    ticks during SET leave time frozen; mode -> RUN with ss=00.
//  - tick_1s and mode_btn same cycle at 08:15:30 -> 08:15:31 and set_field=01.
//  - TOD_ALARM_EN: alarm 07:30, arm=1, run from 07:29:58 -> alarm_ring high at
//    07:30:00; inc_btn pulse clears it without changing mm; unsilenced clears at 07:31:00.

Source files
------------

// File: rtl/tod_pkg.sv
// Shared FSM encodings, BCD limits and the BCD increment helper for the
// time-of-day counter.
package tod_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SET_HH = 2'b01,
    SET_MM = 2'b10
  } tod_state_t;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_SET_HH = 2'b01;
  localparam logic [1:0] ST_SET_MM = 2'b10;

  localparam logic [1:0] SET_FIELD_RUN = 2'b00;
  localparam logic [1:0] SET_FIELD_HH  = 2'b01;
  localparam logic [1:0] SET_FIELD_MM  = 2'b10;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

  // Values at or past the limit, including corrupt digits, wrap to 00.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v >= max_v)
      r = 8'h00;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed BCD counter that wraps at MAX_BCD; carry flags the wrapping
// increment so the next field up can chain on it.
module bcd_mod_counter
  import tod_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_value <= RST_VAL;
    else if (clr)
      r_value <= 8'h00;
    else if (inc)
      r_value <= bcd_next(r_value, MAX_BCD);
  end

  assign value = r_value;
  assign carry = inc && (r_value == MAX_BCD);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day keeper with a RUN/SET_HH/SET_MM edit FSM.
// Optional alarm enabled by defining TOD_ALARM_EN.
module time_of_day_counter
  import tod_pkg::*;
#(
  parameter logic [7:0] RST_HH = 8'h12,
  parameter logic [7:0] RST_MM = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       mode_btn,
  input  logic       inc_btn,
`ifdef TOD_ALARM_EN
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       alarm_ring,
`endif
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [1:0] set_field,
  output logic       day_wrap
);

  logic [1:0] r_state;
  logic [1:0] r_set_field;
  logic       r_day_wrap;
  logic [1:0] w_state_nxt;
  logic       w_run, w_set_hh, w_set_mm;
  logic       w_silence, w_mode, w_inc;
  logic       w_ss_inc, w_mm_inc, w_hh_inc, w_ss_clr;
  logic       w_ss_carry, w_mm_carry, w_hh_carry;

  assign w_run    = (r_state == ST_RUN);
  assign w_set_hh = (r_state == ST_SET_HH);
  assign w_set_mm = (r_state == ST_SET_MM);

  // A button press that silences a ringing alarm is consumed entirely.
  assign w_mode = mode_btn & ~w_silence;
  assign w_inc  = inc_btn & ~w_silence;

  assign w_ss_inc = w_run & tick_1s;
  assign w_ss_clr = w_set_mm & w_mode;
  assign w_mm_inc = (w_run & w_ss_carry) | (w_set_mm & w_inc & ~w_mode);
  assign w_hh_inc = (w_run & w_mm_carry) | (w_set_hh & w_inc & ~w_mode);

  bcd_mod_counter #(.MAX_BCD(BCD_59), .RST_VAL(8'h00)) u_ss (
    .clk(clk), .reset(reset), .inc(w_ss_inc), .clr(w_ss_clr),
    .value(ss_bcd), .carry(w_ss_carry)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59), .RST_VAL(RST_MM)) u_mm (
    .clk(clk), .reset(reset), .inc(w_mm_inc), .clr(1'b0),
    .value(mm_bcd), .carry(w_mm_carry)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_23), .RST_VAL(RST_HH)) u_hh (
    .clk(clk), .reset(reset), .inc(w_hh_inc), .clr(1'b0),
    .value(hh_bcd), .carry(w_hh_carry)
  );

  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN:    w_state_nxt = w_mode ? ST_SET_HH : ST_RUN;
      ST_SET_HH: w_state_nxt = w_mode ? ST_SET_MM : ST_SET_HH;
      ST_SET_MM: w_state_nxt = w_mode ? ST_RUN    : ST_SET_MM;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // set_field mirrors the next state so it never shows the illegal encoding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_set_field <= SET_FIELD_RUN;
      r_day_wrap  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_set_field <= w_state_nxt;
      r_day_wrap  <= w_run & w_hh_carry;
    end
  end

  assign set_field = r_set_field;
  assign day_wrap  = r_day_wrap;

`ifdef TOD_ALARM_EN
  logic r_alarm_ring;
  logic w_alarm_hit;

  // Match against the time this update produces: a seconds wrap means mm
  // advances, and hh advances only if mm wraps too.
  assign w_alarm_hit = w_run & w_ss_carry & alarm_arm &
                       (alarm_mm == bcd_next(mm_bcd, BCD_59)) &
                       (alarm_hh == (w_mm_carry ? bcd_next(hh_bcd, BCD_23) : hh_bcd));
  assign w_silence   = r_alarm_ring & (mode_btn | inc_btn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_alarm_ring <= 1'b0;
    else if (!alarm_arm)
      r_alarm_ring <= 1'b0;
    else if (w_alarm_hit)
      r_alarm_ring <= 1'b1;
    else if (w_silence || (r_alarm_ring && w_run && w_ss_carry))
      r_alarm_ring <= 1'b0;
  end

  assign alarm_ring = r_alarm_ring;
`else
  assign w_silence = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter; alarm scenarios are
// compiled in when TOD_ALARM_EN is defined.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1s = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic [1:0] set_field;
  logic       day_wrap;
`ifdef TOD_ALARM_EN
  logic [7:0] alarm_hh = 8'h07;
  logic [7:0] alarm_mm = 8'h30;
  logic       alarm_arm = 1'b1;
  logic       alarm_ring;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  time_of_day_counter dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .mode_btn(mode_btn), .inc_btn(inc_btn),
`ifdef TOD_ALARM_EN
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm_ring(alarm_ring),
`endif
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .set_field(set_field), .day_wrap(day_wrap)
  );

  // Inputs change on the falling edge; outputs are read on the falling edge after.
  task automatic step(input logic t, input logic m, input logic i);
    tick_1s = t; mode_btn = m; inc_btn = i;
    @(posedge clk);
    @(negedge clk);
    tick_1s = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
  endtask

  task automatic steps(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // From the reset time 12:00, advance hh and mm by the given increments.
  task automatic set_time(input int hinc, input int minc);
    step(0, 1, 0);
    steps(hinc, 0, 0, 1);
    step(0, 1, 0);
    steps(minc, 0, 0, 1);
    step(0, 1, 0);
  endtask

  task automatic test_reset();
    steps(3, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h120000) begin
      $display("FAIL reset_time: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h120000); n_fail++;
    end
    n_tests++;
    if (set_field !== 2'b00 || day_wrap !== 1'b0) begin
      $display("FAIL reset_ctrl: got field=%b wrap=%b required field=00 wrap=0", set_field, day_wrap); n_fail++;
    end
    n_tests++;
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h120001) begin
      $display("FAIL first_tick: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h120001); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_day_wrap();
    do_reset();
    set_time(11, 59);
    steps(58, 1, 0, 0);
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, day_wrap} !== {24'h235959, 1'b0}) begin
      $display("FAIL wrap_pre: got %h wrap=%b required 235959 wrap=0", {hh_bcd, mm_bcd, ss_bcd}, day_wrap); n_fail++;
    end
    n_tests++;
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, day_wrap} !== {24'h000000, 1'b1}) begin
      $display("FAIL wrap_roll: got %h wrap=%b required 000000 wrap=1", {hh_bcd, mm_bcd, ss_bcd}, day_wrap); n_fail++;
    end
    n_tests++;
    step(0, 0, 0);
    if (day_wrap !== 1'b0) begin
      $display("FAIL wrap_pulse: got wrap=%b required 0", day_wrap); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_minute_carry();
    do_reset();
    set_time(22, 59);
    steps(10, 1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h105910) begin
      $display("FAIL ss_tens: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h105910); n_fail++;
    end
    n_tests++;
    steps(49, 1, 0, 0);
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, day_wrap} !== {24'h110000, 1'b0}) begin
      $display("FAIL hour_carry: got %h wrap=%b required 110000 wrap=0", {hh_bcd, mm_bcd, ss_bcd}, day_wrap); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_set_mode();
    do_reset();
    steps(5, 1, 0, 0);
    step(0, 1, 0);
    if (set_field !== 2'b01) begin
      $display("FAIL field_hh: got %b required 01", set_field); n_fail++;
    end
    n_tests++;
    steps(13, 0, 0, 1);
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010005) begin
      $display("FAIL set_hh_wrap: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h010005); n_fail++;
    end
    n_tests++;
    step(0, 1, 0);
    if (set_field !== 2'b10) begin
      $display("FAIL field_mm: got %b required 10", set_field); n_fail++;
    end
    n_tests++;
    step(0, 0, 1);
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010105) begin
      $display("FAIL set_mm_frozen: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h010105); n_fail++;
    end
    n_tests++;
    step(0, 1, 1);
    if ({hh_bcd, mm_bcd, ss_bcd, set_field} !== {24'h010100, 2'b00}) begin
      $display("FAIL leave_set: got %h field=%b required 010100 field=00", {hh_bcd, mm_bcd, ss_bcd}, set_field); n_fail++;
    end
    n_tests++;
    step(0, 0, 1);
    if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010100) begin
      $display("FAIL inc_in_run: got %h required %h", {hh_bcd, mm_bcd, ss_bcd}, 24'h010100); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_set_mm_wrap();
    do_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    steps(61, 0, 0, 1);
    if ({hh_bcd, mm_bcd} !== 16'h1201) begin
      $display("FAIL mm_wrap_no_carry: got %h required %h", {hh_bcd, mm_bcd}, 16'h1201); n_fail++;
    end
    n_tests++;
    step(0, 1, 0);
  endtask

  task automatic test_tick_and_mode();
    do_reset();
    set_time(20, 15);
    steps(30, 1, 0, 0);
    step(1, 1, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, set_field} !== {24'h081531, 2'b01}) begin
      $display("FAIL tick_mode: got %h field=%b required 081531 field=01", {hh_bcd, mm_bcd, ss_bcd}, set_field); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    step(0, 1, 0);
    steps(3, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    if ({hh_bcd, mm_bcd, ss_bcd, set_field} !== {24'h120000, 2'b00}) begin
      $display("FAIL reset_edit: got %h field=%b required 120000 field=00", {hh_bcd, mm_bcd, ss_bcd}, set_field); n_fail++;
    end
    n_tests++;
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef TOD_ALARM_EN
  task automatic test_alarm();
    // Silenced by inc_btn.
    do_reset();
    set_time(19, 29);
    steps(59, 1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, alarm_ring} !== {24'h072959, 1'b0}) begin
      $display("FAIL alarm_pre: got %h ring=%b required 072959 ring=0", {hh_bcd, mm_bcd, ss_bcd}, alarm_ring); n_fail++;
    end
    n_tests++;
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, alarm_ring} !== {24'h073000, 1'b1}) begin
      $display("FAIL alarm_rise: got %h ring=%b required 073000 ring=1", {hh_bcd, mm_bcd, ss_bcd}, alarm_ring); n_fail++;
    end
    n_tests++;
    step(0, 0, 1);
    if ({hh_bcd, mm_bcd, ss_bcd, alarm_ring} !== {24'h073000, 1'b0}) begin
      $display("FAIL alarm_inc_silence: got %h ring=%b required 073000 ring=0", {hh_bcd, mm_bcd, ss_bcd}, alarm_ring); n_fail++;
    end
    n_tests++;
    // Unsilenced: times out after 60 s.
    do_reset();
    set_time(19, 29);
    steps(60, 1, 0, 0);
    steps(59, 1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, alarm_ring} !== {24'h073059, 1'b1}) begin
      $display("FAIL alarm_hold: got %h ring=%b required 073059 ring=1", {hh_bcd, mm_bcd, ss_bcd}, alarm_ring); n_fail++;
    end
    n_tests++;
    step(1, 0, 0);
    if ({hh_bcd, mm_bcd, ss_bcd, alarm_ring} !== {24'h073100, 1'b0}) begin
      $display("FAIL alarm_timeout: got %h ring=%b required 073100 ring=0", {hh_bcd, mm_bcd, ss_bcd}, alarm_ring); n_fail++;
    end
    n_tests++;
    // Silenced by mode_btn, which must not enter SET_HH.
    do_reset();
    set_time(19, 29);
    steps(60, 1, 0, 0);
    step(0, 1, 0);
    if ({alarm_ring, set_field} !== {1'b0, 2'b00}) begin
      $display("FAIL alarm_mode_silence: got ring=%b field=%b required ring=0 field=00", alarm_ring, set_field); n_fail++;
    end
    n_tests++;
    // Disarming clears it.
    do_reset();
    set_time(19, 29);
    steps(60, 1, 0, 0);
    alarm_arm = 1'b0;
    step(0, 0, 0);
    alarm_arm = 1'b1;
    if (alarm_ring !== 1'b0) begin
      $display("FAIL alarm_disarm: got ring=%b required 0", alarm_ring); n_fail++;
    end
    n_tests++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_day_wrap();
    test_minute_carry();
    test_set_mode();
    test_set_mm_wrap();
    test_tick_and_mode();
    test_reset_mid_edit();
`ifdef TOD_ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
